// File: rtl/dp_controller_if.sv
// Instruction handshake between the issuing stage and dp_controller.
interface dp_controller_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/dp_controller.sv
// Sequencing FSM for the register/shift/ALU datapath. Accepts one ARM data-processing
// instruction, checks its condition against the status word and steps the datapath
// through read-A, read-B, execute and writeback.
module dp_controller #(
  parameter bit COND_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  dp_controller_if.slave  instr_if,
  input  logic [31:0]     status_in,
  output logic [31:0]     datapath_in_o,
  output logic            wb_sel,
  output logic [3:0]      w_addr,
  output logic [3:0]      r_addr,
  output logic            w_en,
  output logic            en_A,
  output logic            en_B,
  output logic            en_C,
  output logic            en_status,
  output logic [1:0]      shift_op,
  output logic            sel_A,
  output logic            sel_B,
  output logic [2:0]      ALU_op,
  output logic            done,
  output logic            executed,
  output logic            illegal
);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StExec, StWb, StSkip} state_e;

  localparam logic [3:0] OpcAnd = 4'b0000;
  localparam logic [3:0] OpcEor = 4'b0001;
  localparam logic [3:0] OpcSub = 4'b0010;
  localparam logic [3:0] OpcAdd = 4'b0100;
  localparam logic [3:0] OpcCmp = 4'b1010;
  localparam logic [3:0] OpcOrr = 4'b1100;
  localparam logic [3:0] OpcMov = 4'b1101;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  // Only N,Z,C,V of the status word matter here.
  logic unused_status;
  assign unused_status = ^status_in[27:0];

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [31:0] ins);
    logic opc_ok;
    case (ins[24:21])
      OpcAnd, OpcEor, OpcSub, OpcAdd, OpcCmp, OpcOrr, OpcMov: opc_ok = 1'b1;
      default:                                                opc_ok = 1'b0;
    endcase
    is_legal = opc_ok && (ins[27:26] == 2'b00);
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] opc);
    case (opc)
      OpcAnd:         alu_of = 3'b010;
      OpcEor:         alu_of = 3'b100;
      OpcSub, OpcCmp: alu_of = 3'b001;
      OpcOrr:         alu_of = 3'b011;
      default:        alu_of = 3'b000;
    endcase
  endfunction

  logic [3:0] opc;
  logic       is_cmp;
  logic       accept_ok;
  assign opc       = ir_q[24:21];
  assign is_cmp    = (opc == OpcCmp);
  assign accept_ok = !COND_EN || cond_pass(instr_if.instr[31:28], status_in[31:28]);

  // State, instruction and illegal-flag registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ir_q      <= 32'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: decode and condition check happen on the incoming word at accept.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: begin
        if (instr_if.instr_valid) begin
          ir_d = instr_if.instr;
          if (!is_legal(instr_if.instr)) begin
            illegal_d = 1'b1;
            state_d   = StSkip;
          end else begin
            illegal_d = 1'b0;
            state_d   = accept_ok ? StRdA : StSkip;
          end
        end
      end
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      StSkip:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath controls are a pure function of the state so reset clears them at once.
  always_comb begin
    instr_if.instr_ready = 1'b0;
    r_addr    = 4'h0;
    w_addr    = 4'h0;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    shift_op  = 2'b00;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    ALU_op    = 3'b000;
    done      = 1'b0;
    executed  = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      StIdle: instr_if.instr_ready = 1'b1;
      StRdA: begin
        r_addr = ir_q[19:16];
        en_A   = 1'b1;
      end
      StRdB: begin
        r_addr = ir_q[3:0];
        en_B   = 1'b1;
      end
      StExec: begin
        ALU_op    = alu_of(opc);
        sel_A     = (opc == OpcMov);
        sel_B     = ir_q[25];
        shift_op  = ir_q[6:5];
        en_C      = 1'b1;
        en_status = ir_q[20] | is_cmp;
      end
      StWb: begin
        w_addr   = ir_q[15:12];
        w_en     = !is_cmp;
        done     = 1'b1;
        executed = 1'b1;
      end
      StSkip: begin
        done    = 1'b1;
        illegal = illegal_q;
      end
      default: ;
    endcase
  end

  assign datapath_in_o = ir_q;
  assign wb_sel        = 1'b0;

endmodule
